// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: repeat FSM encoding, NUL code and default timing.
package kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } kr_state_t;

   localparam logic [7:0]  ASCII_NUL      = 8'h00;
   localparam int unsigned DEF_DEPTH      = 8;
   localparam int unsigned DEF_DELAY_CYC  = 50_000_000;
   localparam int unsigned DEF_PERIOD_CYC = 10_000_000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/char_fifo.sv
// Single-clock character FIFO with registered head, occupancy and sticky overflow.
module char_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     out_ready,
   input  logic                     clr_ovf,
   output logic                     out_valid,
   output logic [7:0]               out_ascii,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned FW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr_n;
   logic [FW-1:0] fill_n;
   logic [7:0]    head_n;
   logic          do_pop;
   logic          do_push;
   logic          drop;
   logic          full;

   // Handshake decode; a pop frees a slot for a push in the same cycle.
   always_comb begin
      full     = (fill == FW'(DEPTH));
      do_pop   = out_valid && out_ready;
      do_push  = push && (!full || do_pop);
      drop     = push && full && !do_pop;
      rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;
      fill_n   = fill + FW'(do_push) - FW'(do_pop);
      head_n   = (do_push && (rd_ptr_n == wr_ptr)) ? din : mem[rd_ptr_n];
   end

   always_ff @(posedge clk) begin
      if (rst && do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fill      <= '0;
         out_valid <= 1'b0;
         out_ascii <= 8'h00;
         overflow  <= 1'b0;
      end else begin
         rd_ptr    <= rd_ptr_n;
         wr_ptr    <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         fill      <= fill_n;
         out_valid <= (fill_n != '0);
         out_ascii <= head_n;
         // A drop wins over a clear in the same cycle.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/key_repeat_scheduler.sv
// Typematic key repeat: initial push on make, delayed repeat while held, queued in a FIFO.
module key_repeat_scheduler
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned DELAY_CYC  = DEF_DELAY_CYC,
   parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     key_valid,
   input  logic                     key_make,
   input  logic [7:0]               ascii_in,
   output logic                     out_valid,
   output logic [7:0]               out_ascii,
   input  logic                     out_ready,
   output logic                     overflow,
   input  logic                     clr_ovf,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int unsigned CNT_RAW = $clog2(max_u(DELAY_CYC, PERIOD_CYC));
   localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

   kr_state_t        state;
   kr_state_t        state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [7:0]       held;
   logic [7:0]       held_n;
   logic             key_ev_c;
   logic             push_c;
   logic [7:0]       push_dat_c;
   logic             push_q;
   logic [7:0]       push_dat_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         held       <= 8'h00;
         push_q     <= 1'b0;
         push_dat_q <= 8'h00;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         held       <= held_n;
         push_q     <= push_c;
         push_dat_q <= push_dat_c;
      end
   end

   // Key events pre-empt the timer; unmatched releases let the timer run on.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      held_n     = held;
      push_c     = 1'b0;
      push_dat_c = held;
      key_ev_c   = key_valid && (ascii_in != ASCII_NUL);
      if (key_ev_c && key_make) begin
         push_c     = 1'b1;
         push_dat_c = ascii_in;
         held_n     = ascii_in;
         cnt_n      = CNT_W'(DELAY_CYC - 1);
         state_n    = ST_HOLD;
      end else if (key_ev_c && (state != ST_IDLE) && (ascii_in == held)) begin
         state_n = ST_IDLE;
      end else begin
         unique case (state)
            ST_HOLD, ST_REPEAT: begin
               if (cnt == '0) begin
                  push_c  = 1'b1;
                  cnt_n   = CNT_W'(PERIOD_CYC - 1);
                  state_n = ST_REPEAT;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   char_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .din       (push_dat_q),
      .out_ready (out_ready),
      .clr_ovf   (clr_ovf),
      .out_valid (out_valid),
      .out_ascii (out_ascii),
      .overflow  (overflow),
      .fill      (fill)
   );

endmodule

// File: tb/tb_key_repeat_scheduler.sv
// Directed bench for key_repeat_scheduler with short timing (delay 4, period 2, depth 4).
module tb_key_repeat_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_valid = 1'b0;
   logic       key_make = 1'b0;
   logic [7:0] ascii_in = 8'h00;
   logic       out_valid;
   logic [7:0] out_ascii;
   logic       out_ready = 1'b0;
   logic       overflow;
   logic       clr_ovf = 1'b0;
   logic [2:0] fill;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [7:0] got_dat[$];
   int         got_cyc[$];

   key_repeat_scheduler #(
      .DEPTH      (4),
      .DELAY_CYC  (4),
      .PERIOD_CYC (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_make  (key_make),
      .ascii_in  (ascii_in),
      .out_valid (out_valid),
      .out_ascii (out_ascii),
      .out_ready (out_ready),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf),
      .fill      (fill)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted character with the cycle it was taken.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         got_dat.push_back(out_ascii);
         got_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic key(input logic mk, input logic [7:0] a);
      key_valid = 1'b1;
      key_make  = mk;
      ascii_in  = a;
      step();
      key_valid = 1'b0;
      key_make  = 1'b0;
      ascii_in  = 8'h00;
   endtask

   task automatic clear_log();
      got_dat.delete();
      got_cyc.delete();
   endtask

   int vcount;

   initial begin
      idle(3);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_fill", 32'(fill), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_ascii", 32'(out_ascii), 32'h00);
      rst = 1'b1;
      idle(2);

      // Single tap: one char, latency 2.
      out_ready = 1'b1;
      clear_log();
      key(1'b1, 8'h61);
      chk("tap_lat1_valid", 32'(out_valid), 32'd0);
      key(1'b0, 8'h61);
      chk("tap_lat2_valid", 32'(out_valid), 32'd1);
      chk("tap_lat2_ascii", 32'(out_ascii), 32'h61);
      step();
      chk("tap_drained", 32'(fill), 32'd0);
      idle(10);
      chk("tap_count", 32'(got_dat.size()), 32'd1);
      chk("tap_char", 32'(got_dat[0]), 32'h61);

      // Hold for 12 cycles: pushes at +0, +4, +6, +8, +10.
      clear_log();
      key(1'b1, 8'h61);
      idle(11);
      key(1'b0, 8'h61);
      idle(10);
      chk("hold_count", 32'(got_dat.size()), 32'd5);
      chk("hold_char4", 32'(got_dat[4]), 32'h61);
      chk("hold_first_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd4);
      chk("hold_period_gap", 32'(got_cyc[4] - got_cyc[3]), 32'd2);

      // Roll-over: b replaces a; release of a is ignored.
      clear_log();
      key(1'b1, 8'h61);
      idle(2);
      key(1'b1, 8'h62);
      key(1'b0, 8'h61);
      idle(5);
      key(1'b0, 8'h62);
      idle(10);
      chk("roll_count", 32'(got_dat.size()), 32'd4);
      chk("roll_c0", 32'(got_dat[0]), 32'h61);
      chk("roll_c1", 32'(got_dat[1]), 32'h62);
      chk("roll_c3", 32'(got_dat[3]), 32'h62);

      // Overflow with consumer stalled.
      out_ready = 1'b0;
      clear_log();
      for (int i = 0; i < 6; i++) key(1'b1, 8'(8'h41 + i));
      key(1'b0, 8'h46);
      chk("ovf_fill", 32'(fill), 32'd4);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_head", 32'(out_ascii), 32'h41);
      key(1'b1, 8'h48);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("ovf_drop_beats_clr", 32'(overflow), 32'd1);
      key(1'b0, 8'h48);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      key(1'b1, 8'h47);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("full_pushpop_fill", 32'(fill), 32'd4);
      chk("full_pushpop_head", 32'(out_ascii), 32'h42);
      chk("full_pushpop_ovf", 32'(overflow), 32'd0);
      key(1'b0, 8'h47);
      out_ready = 1'b1;
      idle(8);
      chk("ovf_out_count", 32'(got_dat.size()), 32'd5);
      chk("ovf_out0", 32'(got_dat[0]), 32'h41);
      chk("ovf_out1", 32'(got_dat[1]), 32'h42);
      chk("ovf_out3", 32'(got_dat[3]), 32'h44);
      chk("ovf_out4", 32'(got_dat[4]), 32'h47);
      chk("ovf_drain_fill", 32'(fill), 32'd0);

      // Reset mid-repeat with three queued.
      out_ready = 1'b0;
      clear_log();
      key(1'b1, 8'h63);
      idle(7);
      chk("mid_fill", 32'(fill), 32'd3);
      rst = 1'b0;
      step();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_fill", 32'(fill), 32'd0);
      rst = 1'b1;
      out_ready = 1'b1;
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid) vcount++;
      end
      chk("post_rst_quiet", 32'(vcount), 32'd0);
      chk("post_rst_log", 32'(got_dat.size()), 32'd0);

      // NUL events neither push nor disturb the running timer.
      clear_log();
      key(1'b1, 8'h64);
      key(1'b1, 8'h00);
      key(1'b0, 8'h00);
      idle(2);
      key(1'b0, 8'h64);
      idle(8);
      chk("nul_count", 32'(got_dat.size()), 32'd2);
      chk("nul_c1", 32'(got_dat[1]), 32'h64);
      chk("nul_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd4);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
